// File: rtl/lsu_controller_pkg.sv
// Shared types and constants for the load/store unit controller.
package lsu_controller_pkg;

    localparam int unsigned XLEN = 32;

    // funct3 encodings (loads and stores share the low codes)
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    // Access latched at acceptance and held for the whole transaction
    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } lsu_access_t;

    // True for conflicting requests, unsupported funct3 or misaligned addresses
    function automatic logic access_illegal(input logic rd, input logic wr,
                                            input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (rd && wr) begin
            bad = 1'b1;
        end else if (rd) begin
            case (f3)
                LB, LBU: bad = 1'b0;
                LH, LHU: bad = off[0];
                LW:      bad = (off != 2'b00);
                default: bad = 1'b1;
            endcase
        end else if (wr) begin
            case (f3)
                SB:      bad = 1'b0;
                SH:      bad = off[0];
                SW:      bad = (off != 2'b00);
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_controller_if.sv
// Handshaked data-memory bus between the LSU (master) and memory (slave).
interface lsu_controller_if;
    import lsu_controller_pkg::*;

    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [3:0]      bus_be;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [XLEN-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_controller_data_align.sv
// Byte-lane formatting in both directions: store enables/replication and load extraction.
module lsu_data_align
    import lsu_controller_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be_c,
    output logic [XLEN-1:0] wdata_c,
    output logic [XLEN-1:0] load_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: byte enables and lane-replicated write data
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = '0;
        case (funct3)
            SB: begin
                be_c    = 4'b0001 << offset;
                wdata_c = {4{store_data[7:0]}};
            end
            SH: begin
                be_c    = offset[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{store_data[15:0]}};
            end
            SW: begin
                be_c    = 4'b1111;
                wdata_c = store_data;
            end
            default: ;
        endcase
    end

    // Load side: lane select then sign/zero extension
    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      load_c = {{24{byte_sel[7]}}, byte_sel};
            LH:      load_c = {{16{half_sel[15]}}, half_sel};
            LW:      load_c = rdata;
            LBU:     load_c = {24'd0, byte_sel};
            LHU:     load_c = {16'd0, half_sel};
            default: load_c = '0;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer: accepts one access, runs the bus handshake, stalls the core.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_controller
    import lsu_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [2:0]      rd_wr_mem,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            stall,
    output logic            lsu_err,
    lsu_controller_if.master bus
);

    lsu_state_t      state, next_state;
    lsu_access_t     acc_q;
    logic            access_bad;
    logic            accept, illegal_pulse, capture, timeout_fire, timeout_hit;
    logic            err_q;
    logic            in_req;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata, load_fmt;

    assign access_bad = access_illegal(mem_rd, mem_wr, rd_wr_mem, addr[1:0]);

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;

    // Watchdog counts every cycle spent waiting on the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == REQ || state == WAIT) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == REQ || state == WAIT) &&
                         (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and control decode
    always_comb begin
        next_state    = state;
        stall         = 1'b0;
        accept        = 1'b0;
        illegal_pulse = 1'b0;
        capture       = 1'b0;
        timeout_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_rd || mem_wr) begin
                    if (access_bad) begin
                        illegal_pulse = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        stall      = 1'b1;
                        next_state = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus.bus_gnt) begin
                    next_state = acc_q.we ? DONE : WAIT;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    next_state   = DONE;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus.bus_rvalid) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    next_state   = DONE;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Latch the accepted access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q.we     <= mem_wr;
            acc_q.funct3 <= rd_wr_mem;
            acc_q.addr   <= addr;
            acc_q.data   <= store_data;
        end
    end

    // Load result register; cleared on error or timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_data <= '0;
        end else if (capture) begin
            load_data <= load_fmt;
        end else if (illegal_pulse || timeout_fire) begin
            load_data <= '0;
        end
    end

    // Timeout error flag, high only for the DONE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= timeout_fire;
    end

    lsu_data_align u_align (
        .funct3     (acc_q.funct3),
        .offset     (acc_q.addr[1:0]),
        .store_data (acc_q.data),
        .rdata      (bus.bus_rdata),
        .be_c       (be),
        .wdata_c    (wdata),
        .load_c     (load_fmt)
    );

    assign in_req        = (state == REQ);
    assign lsu_err       = illegal_pulse | err_q;
    assign bus.bus_req   = in_req;
    assign bus.bus_we    = in_req & acc_q.we;
    assign bus.bus_addr  = in_req ? {acc_q.addr[XLEN-1:2], 2'b00} : '0;
    assign bus.bus_be    = in_req ? be : 4'b0000;
    assign bus.bus_wdata = in_req ? wdata : '0;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed self-checking bench for lsu_controller.
module tb_lsu_controller;
    import lsu_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr;
    logic [2:0]  rd_wr_mem;
    logic [31:0] addr, store_data, load_data;
    logic        stall, lsu_err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_we;

    lsu_controller_if bus ();

    lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .rd_wr_mem  (rd_wr_mem),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .lsu_err    (lsu_err),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Run one legal access; returns positioned in the DONE cycle
    task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd,
                              input int gnt_dly, input int rv_dly);
        @(negedge clk);
        mem_rd = ~wr; mem_wr = wr; rd_wr_mem = f3; addr = a; store_data = sd;
        #1 check("stall_idle", 32'(stall), 32'd1);
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b0;
        for (int i = 0; i < gnt_dly; i++) begin
            #1 check("req_hold", 32'(bus.bus_req), 32'd1);
            @(negedge clk);
        end
        bus.bus_gnt = 1'b1;
        #1 check("req", 32'(bus.bus_req), 32'd1);
        req_addr = bus.bus_addr; req_be = bus.bus_be;
        req_wdata = bus.bus_wdata; req_we = bus.bus_we;
        @(negedge clk);
        bus.bus_gnt = 1'b0;
        if (!wr) begin
            for (int i = 0; i < rv_dly; i++) begin
                #1 check("wait_stall", 32'(stall), 32'd1);
                check("wait_noreq", 32'(bus.bus_req), 32'd0);
                @(negedge clk);
            end
            bus.bus_rvalid = 1'b1; bus.bus_rdata = rd;
            @(negedge clk);
            bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'h0;
        end
        #1 check("done_stall", 32'(stall), 32'd0);
        check("done_err", 32'(lsu_err), 32'd0);
    endtask

    // Illegal request: single-cycle error, no bus traffic, load_data cleared
    task automatic err_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input string tag);
        @(negedge clk);
        mem_rd = rd; mem_wr = wr; rd_wr_mem = f3; addr = a;
        #1 check({tag, "_err"}, 32'(lsu_err), 32'd1);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_req"}, 32'(bus.bus_req), 32'd0);
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b0;
        #1 check({tag, "_ld0"}, load_data, 32'd0);
        check({tag, "_pulse"}, 32'(lsu_err), 32'd0);
        check({tag, "_noreq"}, 32'(bus.bus_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; rd_wr_mem = 3'd0;
        addr = 32'h0; store_data = 32'h0;
        bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_err", 32'(lsu_err), 32'd0);
        check("rst_ld", load_data, 32'd0);
        check("rst_req", 32'(bus.bus_req), 32'd0);
        check("rst_be", 32'(bus.bus_be), 32'd0);
        rst = 1'b0;

        run_access(1'b1, SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
        check("sw_addr", req_addr, 32'h100);
        check("sw_be", 32'(req_be), 32'hF);
        check("sw_wdata", req_wdata, 32'hDEADBEEF);
        check("sw_we", 32'(req_we), 32'd1);

        run_access(1'b0, LB, 32'h203, 32'h0, 32'h80112233, 2, 1);
        check("lb_addr", req_addr, 32'h200);
        check("lb_we", 32'(req_we), 32'd0);
        check("lb_data", load_data, 32'hFFFFFF80);
        @(negedge clk);
        #1 check("ld_hold", load_data, 32'hFFFFFF80);

        run_access(1'b0, LBU, 32'h203, 32'h0, 32'h80112233, 0, 0);
        check("lbu_data", load_data, 32'h00000080);

        run_access(1'b1, SH, 32'h12, 32'h0000ABCD, 32'h0, 1, 0);
        check("sh_addr", req_addr, 32'h10);
        check("sh_be", 32'(req_be), 32'hC);
        check("sh_wdata", req_wdata, 32'hABCDABCD);

        run_access(1'b1, SH, 32'h10, 32'h00001234, 32'h0, 0, 0);
        check("sh_lo_be", 32'(req_be), 32'h3);

        run_access(1'b1, SB, 32'h101, 32'h0000005A, 32'h0, 0, 0);
        check("sb_be", 32'(req_be), 32'h2);
        check("sb_wdata", req_wdata, 32'h5A5A5A5A);

        run_access(1'b0, LH, 32'h202, 32'h0, 32'h80112233, 0, 2);
        check("lh_data", load_data, 32'hFFFF8011);

        run_access(1'b0, LHU, 32'h200, 32'h0, 32'h80118233, 0, 0);
        check("lhu_data", load_data, 32'h00008233);

        run_access(1'b0, LB, 32'h201, 32'h0, 32'h80114233, 0, 0);
        check("lb_pos", load_data, 32'h00000042);

        run_access(1'b0, LW, 32'h204, 32'h0, 32'h12345678, 0, 0);
        check("lw_data", load_data, 32'h12345678);

        err_access(1'b1, 1'b0, LW, 32'h101, "lw_mis");
        err_access(1'b1, 1'b1, LW, 32'h100, "rdwr");
        err_access(1'b1, 1'b0, 3'd3, 32'h100, "ld_f3");
        err_access(1'b1, 1'b0, 3'd6, 32'h100, "ld_f6");
        err_access(1'b0, 1'b1, 3'd4, 32'h100, "st_f4");
        err_access(1'b1, 1'b0, LH, 32'h201, "lh_mis");
        err_access(1'b0, 1'b1, SW, 32'h102, "sw_mis");

        // Reset in the middle of a load
        run_access(1'b0, LW, 32'h208, 32'h0, 32'hCAFEF00D, 0, 0);
        check("lw2_data", load_data, 32'hCAFEF00D);
        @(negedge clk);
        mem_rd = 1'b1; rd_wr_mem = LW; addr = 32'h300;
        @(negedge clk);
        mem_rd = 1'b0; bus.bus_gnt = 1'b1;
        @(negedge clk);
        bus.bus_gnt = 1'b0;
        #1 check("wait_stall_r", 32'(stall), 32'd1);
        #2 rst = 1'b1;
        #1 check("rst_wait_stall", 32'(stall), 32'd0);
        check("rst_wait_ld", load_data, 32'd0);
        check("rst_wait_req", 32'(bus.bus_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus.bus_rvalid = 1'b0;
        #1 check("late_rv_ld", load_data, 32'd0);
        check("late_rv_stall", 32'(stall), 32'd0);
        check("late_rv_req", 32'(bus.bus_req), 32'd0);

        run_access(1'b0, LW, 32'h20C, 32'h0, 32'h0BADF00D, 0, 0);
        check("post_rst_lw", load_data, 32'h0BADF00D);

`ifdef LSU_TIMEOUT_EN
        @(negedge clk);
        mem_rd = 1'b1; rd_wr_mem = LW; addr = 32'h400;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rd = 1'b0;
            #1 check("tmo_req", 32'(bus.bus_req), 32'd1);
        end
        @(negedge clk);
        #1 check("tmo_err", 32'(lsu_err), 32'd1);
        check("tmo_stall", 32'(stall), 32'd0);
        check("tmo_req_off", 32'(bus.bus_req), 32'd0);
        check("tmo_ld", load_data, 32'd0);
        @(negedge clk);
        bus.bus_gnt = 1'b1;
        #1 check("tmo_idle_err", 32'(lsu_err), 32'd0);
        check("tmo_late_gnt", 32'(bus.bus_req), 32'd0);
        @(negedge clk);
        bus.bus_gnt = 1'b0;
        #1 check("tmo_late_stall", 32'(stall), 32'd0);
        run_access(1'b0, LW, 32'h404, 32'h0, 32'h11112222, 0, 0);
        check("tmo_lw1", load_data, 32'h11112222);
        run_access(1'b0, LW, 32'h408, 32'h0, 32'h33334444, 0, 0);
        check("tmo_lw2", load_data, 32'h33334444);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
